// File: rtl/io_ctrl_pkg.sv
// Shared types and constants for the IN/OUT stall handshake responder.
package io_ctrl_pkg;

    // Handshake progress for one stalled IN/OUT instruction
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        RESUME       = 2'd3
    } io_state_t;

    // Which kind of instruction is being serviced
    localparam logic IO_KIND_IN  = 1'b0;
    localparam logic IO_KIND_OUT = 1'b1;

    // Small default keeps simulation short; the board build overrides it
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stability counter for the operator
// confirm pushbutton. Emits the debounced level and one-cycle press/release
// pulses that coincide with the first cycle of the new level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;
    logic             release_reg;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Flip the level only after a full run of disagreeing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_reg   <= 1'b0;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                cnt_reg     <= '0;
                level_reg   <= sync2_reg;
                press_reg   <= sync2_reg;
                release_reg <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level         = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;

endmodule

// File: rtl/io_handshake_controller.sv
// Responder for the processor's IN/OUT stall: captures switches or drives the
// display, then waits for an operator press/release before releasing the PC.
module io_handshake_controller
    import io_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SW_W            = 16,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req,
    input  logic              out_req,
    input  logic [DATA_W-1:0] out_data,
    input  logic [SW_W-1:0]   sw_data,
    input  logic              confirm_btn,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic [DATA_W-1:0] display_data,
    output logic              resume,
    output logic              io_busy
);

    io_state_t         state_reg;
    logic              kind_reg;
    logic [DATA_W-1:0] in_data_reg;
    logic              in_valid_reg;
    logic [DATA_W-1:0] display_reg;
    logic              resume_reg;
    logic              busy_reg;

    logic btn_level;
    logic btn_press;
    logic btn_release;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (confirm_btn),
        .level        (btn_level),
        .press_pulse  (btn_press),
        .release_pulse(btn_release)
    );

    // Handshake FSM; all outputs registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            kind_reg     <= IO_KIND_IN;
            in_data_reg  <= '0;
            in_valid_reg <= 1'b0;
            display_reg  <= '0;
            resume_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            in_valid_reg <= 1'b0;
            resume_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // IN takes priority when decode flags both
                    if (in_req) begin
                        kind_reg  <= IO_KIND_IN;
                        state_reg <= WAIT_PRESS;
                        busy_reg  <= 1'b1;
                    end else if (out_req) begin
                        kind_reg    <= IO_KIND_OUT;
                        display_reg <= out_data;
                        state_reg   <= WAIT_PRESS;
                        busy_reg    <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    // A press pulse always coincides with a high level; a
                    // button already held on entry produces no pulse here
                    if (btn_press && btn_level) begin
                        if (kind_reg == IO_KIND_IN) begin
                            in_data_reg  <= DATA_W'(sw_data);
                            in_valid_reg <= 1'b1;
                        end
                        state_reg <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (btn_release) begin
                        state_reg  <= RESUME;
                        resume_reg <= 1'b1;
                    end
                end
                RESUME: begin
                    // Requests are ignored here; the PC has not moved yet
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign in_data      = in_data_reg;
    assign in_valid     = in_valid_reg;
    assign display_data = display_reg;
    assign resume       = resume_reg;
    assign io_busy      = busy_reg;

endmodule

// File: tb/tb_io_handshake_controller.sv
// Directed bench for io_handshake_controller: table of full transactions plus
// hand-written sequences for reset, bounce, held button and mid-op reset.
module tb_io_handshake_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_req = 1'b0;
    logic        out_req = 1'b0;
    logic [31:0] out_data = '0;
    logic [15:0] sw_data = '0;
    logic        confirm_btn = 1'b0;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] display_data;
    logic        resume;
    logic        io_busy;

    int errors = 0;
    int checks = 0;

    io_handshake_controller dut (
        .clk         (clk),
        .reset       (reset),
        .in_req      (in_req),
        .out_req     (out_req),
        .out_data    (out_data),
        .sw_data     (sw_data),
        .confirm_btn (confirm_btn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .display_data(display_data),
        .resume      (resume),
        .io_busy     (io_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        in_req;
        logic        out_req;
        logic [15:0] sw;
        logic [31:0] out_data;
        logic [31:0] exp_in_data;
        logic [31:0] exp_display;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Press for 8 cycles; an IN pulse must appear exactly 7 cycles after the rise
    task automatic press_and_check(input logic expect_valid);
        int vcount = 0;
        int vidx = 0;
        int rcount = 0;
        confirm_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (in_valid === 1'b1) begin
                vcount++;
                vidx = i;
            end
            if (resume === 1'b1) rcount++;
        end
        check("in_valid_count", 32'(vcount), expect_valid ? 32'd1 : 32'd0);
        if (expect_valid) check("in_valid_latency", 32'(vidx), 32'd7);
        check("resume_during_press", 32'(rcount), 32'd0);
        check("busy_after_press", {31'd0, io_busy}, 32'd1);
    endtask

    // Release; resume must appear 7 cycles after the fall, busy low the next cycle
    task automatic release_and_check();
        int rcount = 0;
        int ridx = 0;
        int vcount = 0;
        confirm_btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (resume === 1'b1) begin
                rcount++;
                ridx = i;
                in_req  = 1'b0;
                out_req = 1'b0;
            end
            if (in_valid === 1'b1) vcount++;
            if (i == 8) check("busy_after_resume", {31'd0, io_busy}, 32'd0);
        end
        check("resume_count", 32'(rcount), 32'd1);
        check("resume_latency", 32'(ridx), 32'd7);
        check("in_valid_during_release", 32'(vcount), 32'd0);
        in_req  = 1'b0;
        out_req = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'hA5A5, 32'h0000_0000, 32'h0000_A5A5, 32'h0000_0000, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 32'hDEAD_BEEF, 32'h0000_A5A5, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 32'h1111_1111, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 16'h5555, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h5555, 32'h1234_5678, 32'h0000_FFFF, 32'h1234_5678, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h0001, 32'h8765_4321, 32'h0000_0001, 32'h1234_5678, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 16'hBEEF, 32'hFFFF_FFFF, 32'h0000_BEEF, 32'h1234_5678, 1'b1};

        // Reset held with button and OUT request active: nothing may move
        confirm_btn = 1'b1;
        out_req     = 1'b1;
        out_data    = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_display", display_data, 32'h0);
            check("rst_in_valid", {31'd0, in_valid}, 32'd0);
            check("rst_resume", {31'd0, resume}, 32'd0);
            check("rst_busy", {31'd0, io_busy}, 32'd0);
        end
        reset       = 1'b1;
        out_req     = 1'b0;
        confirm_btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("post_rst_busy", {31'd0, io_busy}, 32'd0);
        check("post_rst_display", display_data, 32'h0);
        check("post_rst_in_data", in_data, 32'h0);
        $display("txn reset: display=%h busy=%b", display_data, io_busy);

        // Table of complete transactions
        for (int v = 0; v < 7; v++) begin
            in_req   = vecs[v].in_req;
            out_req  = vecs[v].out_req;
            sw_data  = vecs[v].sw;
            out_data = vecs[v].out_data;
            tick();
            check("req_busy", {31'd0, io_busy}, 32'd1);
            check("req_display", display_data, vecs[v].exp_display);
            press_and_check(vecs[v].exp_valid);
            release_and_check();
            check("vec_in_data", in_data, vecs[v].exp_in_data);
            check("vec_display", display_data, vecs[v].exp_display);
            $display("txn vec%0d: in_data=%h display=%h", v, in_data, display_data);
        end

        // Bounce in WAIT_PRESS: never stable long enough to count
        begin
            int vcount = 0;
            int rcount = 0;
            int idle_seen = 0;
            in_req  = 1'b1;
            sw_data = 16'h3C3C;
            tick();
            for (int i = 0; i < 40; i++) begin
                confirm_btn = ((i / 2) % 2 == 0);
                tick();
                if (in_valid === 1'b1) vcount++;
                if (resume === 1'b1) rcount++;
                if (io_busy !== 1'b1) idle_seen++;
            end
            confirm_btn = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            check("bounce_in_valid", 32'(vcount), 32'd0);
            check("bounce_resume", 32'(rcount), 32'd0);
            check("bounce_busy", 32'(idle_seen), 32'd0);
            check("bounce_in_data_held", in_data, 32'h0000_BEEF);
            press_and_check(1'b1);
            release_and_check();
            check("bounce_in_data", in_data, 32'h0000_3C3C);
            $display("txn bounce: in_data=%h", in_data);
        end

        // Button already held when simultaneous requests arrive
        begin
            int vcount = 0;
            int rcount = 0;
            confirm_btn = 1'b1;
            for (int i = 0; i < 10; i++) tick();
            check("held_idle_busy", {31'd0, io_busy}, 32'd0);
            sw_data  = 16'h1234;
            out_data = 32'hCAFE_F00D;
            in_req   = 1'b1;
            out_req  = 1'b1;
            tick();
            check("held_busy", {31'd0, io_busy}, 32'd1);
            check("held_display", display_data, 32'h1234_5678);
            for (int i = 0; i < 10; i++) begin
                tick();
                if (in_valid === 1'b1) vcount++;
                if (resume === 1'b1) rcount++;
            end
            confirm_btn = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (in_valid === 1'b1) vcount++;
                if (resume === 1'b1) rcount++;
            end
            check("held_no_valid", 32'(vcount), 32'd0);
            check("held_no_resume", 32'(rcount), 32'd0);
            check("held_still_busy", {31'd0, io_busy}, 32'd1);
            press_and_check(1'b1);
            release_and_check();
            check("held_in_data", in_data, 32'h0000_1234);
            check("held_display_after", display_data, 32'h1234_5678);
            $display("txn held: in_data=%h display=%h", in_data, display_data);
        end

        // Reset asserted while waiting for release
        begin
            int vcount = 0;
            int rcount = 0;
            int busy_seen = 0;
            out_req  = 1'b1;
            out_data = 32'h0BAD_F00D;
            tick();
            check("midrst_display_set", display_data, 32'h0BAD_F00D);
            press_and_check(1'b0);
            reset = 1'b0;
            #1;
            check("midrst_busy", {31'd0, io_busy}, 32'd0);
            check("midrst_display", display_data, 32'h0);
            out_req     = 1'b0;
            confirm_btn = 1'b0;
            tick();
            tick();
            reset = 1'b1;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (in_valid === 1'b1) vcount++;
                if (resume === 1'b1) rcount++;
                if (io_busy === 1'b1) busy_seen++;
            end
            check("midrst_no_resume", 32'(rcount), 32'd0);
            check("midrst_no_valid", 32'(vcount), 32'd0);
            check("midrst_idle", 32'(busy_seen), 32'd0);
            check("midrst_display_after", display_data, 32'h0);
            $display("txn midreset: display=%h busy=%b", display_data, io_busy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_handshake_controller.md
Name: io_handshake_controller

Overview:
Responder side of the processor's IN/OUT stall protocol. When decode flags an IN or OUT instruction, the program counter freezes. This block then services the request:
- IN: captures the switch bank into a register-write value.
- OUT: latches a register value onto the display.
- Waits for a debounced operator confirm press and release, then issues a one-cycle resume pulse (the PC's switchIO input) that releases the stall.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to change debounced button level (hardware build uses 500000)
SW_W, 16, width of switch bank; zero-extended to 32 bits on IN
DATA_W, 32, datapath width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
in_req  in  1  level, decoded IN instruction present (held while stalled)
out_req  in  1  level, decoded OUT instruction present (held while stalled)
out_data  in  DATA_W  register value to display on OUT
sw_data  in  SW_W  switch bank, quasi-static
confirm_btn  in  1  raw asynchronous pushbutton, active-high
in_data  out  DATA_W  value for register file on IN
in_valid  out  1  one-cycle write strobe for in_data
display_data  out  DATA_W  display register
resume  out  1  one-cycle pulse to PC switchIO
io_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, in_data=0, in_valid=0, display_data=0, resume=0, io_busy=0, synchronizer flops=0, debounced level=0, debounce counter=0.
- Button path: 2-flop synchronizer, then debouncer.
  - Debounced level flips after the synchronized sample differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any sample equal to the current level clears the counter.
  - Press edge = debounced 0->1; release edge = debounced 1->0.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, RESUME.
- IDLE:
  - in_req=1 -> record kind=IN, go to WAIT_PRESS.
  - else out_req=1 -> record kind=OUT, display_data<=out_data on the same edge, go to WAIT_PRESS.
  - in_req and out_req both high: IN wins; display_data unchanged.
- WAIT_PRESS:
  - Only a press edge seen in this state counts. A button already held on entry must be released and pressed again.
  - On press edge with kind=IN: in_data<=zero-extended sw_data sampled that edge; in_valid=1 next cycle for exactly 1 cycle.
  - On any press edge: go to WAIT_RELEASE.
- WAIT_RELEASE: release edge -> go to RESUME.
- RESUME:
  - resume=1 for exactly this cycle; in_req/out_req ignored.
  - Next state is IDLE. The PC updates on the following negedge, so requests sampled in IDLE belong to the next instruction.
  - Back-to-back IN instructions each require their own press/release.
- Request drops while in WAIT_* (should not happen while the PC is stalled): transaction still completes; no abort.
- in_data and display_data hold their values until overwritten or reset.
- Latency, DEBOUNCE_CYCLES=4, clean press: raw rise -> debounced rise in 2+4 cycles -> in_valid 1 cycle later.
- Reset asserted mid-transaction: immediate return to IDLE; no in_valid or resume emitted; display_data=0.

Decomposition:
- Package io_ctrl_pkg: FSM state enum (IDLE, WAIT_PRESS, WAIT_RELEASE, RESUME); kind constants IO_KIND_IN, IO_KIND_OUT; default DEBOUNCE_CYCLES.
- One sub-module, button_debouncer: synchronizer + counter. Outputs debounced level plus press/release edge pulses; parameter DEBOUNCE_CYCLES; same clk/reset.

Test Plan:
- Reset: hold reset=0 with confirm_btn=1, out_req=1 -> display_data=0, in_valid=0, resume=0, io_busy=0 throughout; release reset, drop requests -> still idle.
- IN: sw_data=16'hA5A5, in_req=1, press 8 cycles then release -> in_data=32'h0000A5A5 with a single in_valid pulse 7 cycles after raw rise; one resume pulse 7 cycles after raw fall; io_busy low the cycle after.
- OUT: out_data=32'hDEADBEEF, out_req=1 -> display_data=32'hDEADBEEF one cycle later; press/release -> no in_valid, exactly one resume.
- Bounce: in WAIT_PRESS, toggle confirm_btn every 2 cycles for 40 cycles -> no in_valid, no resume, state stays WAIT_PRESS.
- Held button and simultaneous requests: button already high when in_req=1 and out_req=1 arrive -> no action until release then press; serviced as IN, display_data unchanged.
- Reset mid-operation: assert reset in WAIT_RELEASE -> io_busy=0 immediately, no resume ever, display_data=0.
